// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator.
// Divides the system clock down to a pixel-rate enable. Walks the horizontal
// and vertical counters, and produces registered active-area and sync flags.
// It also produces a once-per-frame tick at the start of vertical blanking.
//
// Ports:
//   clk         system clock, all state changes on posedge
//   rst_n       asynchronous active-low reset
//   pix_en      pixel-rate enable, one clk wide every CLK_DIV clocks
//   h_cnt       horizontal pixel position, 0..H_TOTAL-1
//   v_cnt       vertical line position, 0..V_TOTAL-1
//   valid       high while (h_cnt, v_cnt) is inside the visible area
//   hsync       horizontal sync, SYNC_POL inside the sync window
//   vsync       vertical sync, SYNC_POL inside the sync window
//   frame_tick  one-clk pulse when the counters have just become (0, V_ACTIVE)
module vga_timing_gen #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_en,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       valid,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick
);

    localparam int unsigned CNT_W    = 10;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_pix_en;
    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    logic             r_valid;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_tick;

    logic [DIV_W-1:0] w_div_next;
    logic             w_pix_en_next;
    logic             w_h_wrap;
    logic [CNT_W-1:0] w_h_next;
    logic [CNT_W-1:0] w_v_next;
    logic             w_valid_next;
    logic             w_hsync_next;
    logic             w_vsync_next;
    logic             w_tick_next;

    // Next-state logic. pix_en is registered from the next divider value so it
    // is high exactly while r_div == CLK_DIV-1. Flags are derived from the
    // next coordinates so they stay aligned with h_cnt/v_cnt.
    always_comb begin
        w_div_next    = (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
        w_pix_en_next = (w_div_next == DIV_LAST);

        w_h_wrap = (r_h == H_LAST);
        w_h_next = w_h_wrap ? '0 : r_h + CNT_W'(1);
        w_v_next = r_v;
        if (w_h_wrap) begin
            w_v_next = (r_v == V_LAST) ? '0 : r_v + CNT_W'(1);
        end

        w_valid_next = (w_h_next < CNT_W'(H_ACTIVE)) && (w_v_next < CNT_W'(V_ACTIVE));
        w_hsync_next = ((w_h_next >= CNT_W'(HS_START)) && (w_h_next < CNT_W'(HS_END)))
                       ? SYNC_POL : ~SYNC_POL;
        w_vsync_next = ((w_v_next >= CNT_W'(VS_START)) && (w_v_next < CNT_W'(VS_END)))
                       ? SYNC_POL : ~SYNC_POL;

        // Fires only on the step into line V_ACTIVE at column 0
        w_tick_next = r_pix_en && w_h_wrap && (w_v_next == CNT_W'(V_ACTIVE));
    end

    // State registers; reset parks the raster on the last blanking pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div    <= '0;
            r_pix_en <= 1'(CLK_DIV == 1);
            r_h      <= H_LAST;
            r_v      <= V_LAST;
            r_valid  <= 1'b0;
            r_hsync  <= ~SYNC_POL;
            r_vsync  <= ~SYNC_POL;
            r_tick   <= 1'b0;
        end else begin
            r_div    <= w_div_next;
            r_pix_en <= w_pix_en_next;
            r_tick   <= w_tick_next;
            if (r_pix_en) begin
                r_h     <= w_h_next;
                r_v     <= w_v_next;
                r_valid <= w_valid_next;
                r_hsync <= w_hsync_next;
                r_vsync <= w_vsync_next;
            end
        end
    end

    assign pix_en     = r_pix_en;
    assign h_cnt      = r_h;
    assign v_cnt      = r_v;
    assign valid      = r_valid;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign frame_tick = r_tick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed self-checking bench for vga_timing_gen.
// The bench has three instances. d0 uses the default 640x480 timing. d1 uses a
// reduced 15x10 raster so that full frames stay short. d2 uses CLK_DIV=1 with
// active-high syncs.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic       d0_pix_en, d0_valid, d0_hsync, d0_vsync, d0_tick;
    logic [9:0] d0_h, d0_v;
    logic       d1_pix_en, d1_valid, d1_hsync, d1_vsync, d1_tick;
    logic [9:0] d1_h, d1_v;
    logic       d2_pix_en, d2_valid, d2_hsync, d2_vsync, d2_tick;
    logic [9:0] d2_h, d2_v;

    vga_timing_gen d0 (
        .clk(clk), .rst_n(rst_n), .pix_en(d0_pix_en), .h_cnt(d0_h), .v_cnt(d0_v),
        .valid(d0_valid), .hsync(d0_hsync), .vsync(d0_vsync), .frame_tick(d0_tick)
    );

    vga_timing_gen #(
        .CLK_DIV(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
    ) d1 (
        .clk(clk), .rst_n(rst_n), .pix_en(d1_pix_en), .h_cnt(d1_h), .v_cnt(d1_v),
        .valid(d1_valid), .hsync(d1_hsync), .vsync(d1_vsync), .frame_tick(d1_tick)
    );

    vga_timing_gen #(.CLK_DIV(1), .SYNC_POL(1'b1)) d2 (
        .clk(clk), .rst_n(rst_n), .pix_en(d2_pix_en), .h_cnt(d2_h), .v_cnt(d2_v),
        .valid(d2_valid), .hsync(d2_hsync), .vsync(d2_vsync), .frame_tick(d2_tick)
    );

    // Pulse reset and release on a negedge; the caller is then in cycle 0
    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (d0_pix_en !== 1'b0) begin errors++; $display("FAIL reset d0 pix_en: got %0b expected 0", d0_pix_en); end
        checks++; if (d0_h !== 10'd799) begin errors++; $display("FAIL reset d0 h_cnt: got %0d expected 799", d0_h); end
        checks++; if (d0_v !== 10'd524) begin errors++; $display("FAIL reset d0 v_cnt: got %0d expected 524", d0_v); end
        checks++; if (d0_valid !== 1'b0) begin errors++; $display("FAIL reset d0 valid: got %0b expected 0", d0_valid); end
        checks++; if (d0_hsync !== 1'b1) begin errors++; $display("FAIL reset d0 hsync: got %0b expected 1", d0_hsync); end
        checks++; if (d0_vsync !== 1'b1) begin errors++; $display("FAIL reset d0 vsync: got %0b expected 1", d0_vsync); end
        checks++; if (d0_tick !== 1'b0) begin errors++; $display("FAIL reset d0 frame_tick: got %0b expected 0", d0_tick); end
        checks++; if (d1_h !== 10'd14) begin errors++; $display("FAIL reset d1 h_cnt: got %0d expected 14", d1_h); end
        checks++; if (d1_v !== 10'd9) begin errors++; $display("FAIL reset d1 v_cnt: got %0d expected 9", d1_v); end
        checks++; if (d2_pix_en !== 1'b1) begin errors++; $display("FAIL reset d2 pix_en: got %0b expected 1", d2_pix_en); end
        checks++; if (d2_hsync !== 1'b0) begin errors++; $display("FAIL reset d2 hsync: got %0b expected 0", d2_hsync); end
        checks++; if (d2_vsync !== 1'b0) begin errors++; $display("FAIL reset d2 vsync: got %0b expected 0", d2_vsync); end
        repeat (2) @(negedge clk);
        checks++; if (d0_h !== 10'd799) begin errors++; $display("FAIL reset hold d0 h_cnt: got %0d expected 799", d0_h); end
    endtask

    // pix_en every 4th clock, first counter wrap to (0,0) with no frame_tick
    task automatic test_pix_en();
        logic exp_pe;
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            exp_pe = ((c % 4) == 3);
            checks++; if (d0_pix_en !== exp_pe) begin errors++; $display("FAIL pix_en cycle %0d: got %0b expected %0b", c, d0_pix_en, exp_pe); end
            if (c < 4) begin
                checks++; if (d0_h !== 10'd799) begin errors++; $display("FAIL pre-wrap h_cnt cycle %0d: got %0d expected 799", c, d0_h); end
            end
            if (c == 4) begin
                checks++; if (d0_h !== 10'd0) begin errors++; $display("FAIL first wrap h_cnt: got %0d expected 0", d0_h); end
                checks++; if (d0_v !== 10'd0) begin errors++; $display("FAIL first wrap v_cnt: got %0d expected 0", d0_v); end
                checks++; if (d0_valid !== 1'b1) begin errors++; $display("FAIL first wrap valid: got %0b expected 1", d0_valid); end
                checks++; if (d0_hsync !== 1'b1) begin errors++; $display("FAIL first wrap hsync: got %0b expected 1", d0_hsync); end
                checks++; if (d0_vsync !== 1'b1) begin errors++; $display("FAIL first wrap vsync: got %0b expected 1", d0_vsync); end
                checks++; if (d0_tick !== 1'b0) begin errors++; $display("FAIL first wrap frame_tick: got %0b expected 0", d0_tick); end
            end
            @(negedge clk);
        end
    endtask

    // One full default line: h 0..799, valid and hsync windows
    task automatic test_line();
        logic exp_valid, exp_hs;
        int   hs_low;
        hs_low = 0;
        apply_reset();
        repeat (4) @(negedge clk);
        for (int i = 0; i < 800; i++) begin
            exp_valid = (i < 640);
            exp_hs    = !((i >= 656) && (i < 752));
            checks++; if (d0_h !== 10'(i)) begin errors++; $display("FAIL line h_cnt px %0d: got %0d expected %0d", i, d0_h, i); end
            checks++; if (d0_v !== 10'd0) begin errors++; $display("FAIL line v_cnt px %0d: got %0d expected 0", i, d0_v); end
            checks++; if (d0_valid !== exp_valid) begin errors++; $display("FAIL line valid px %0d: got %0b expected %0b", i, d0_valid, exp_valid); end
            checks++; if (d0_hsync !== exp_hs) begin errors++; $display("FAIL line hsync px %0d: got %0b expected %0b", i, d0_hsync, exp_hs); end
            if (d0_hsync === 1'b0) hs_low++;
            repeat (4) @(negedge clk);
        end
        checks++; if (d0_h !== 10'd0) begin errors++; $display("FAIL line end h_cnt: got %0d expected 0", d0_h); end
        checks++; if (d0_v !== 10'd1) begin errors++; $display("FAIL line end v_cnt: got %0d expected 1", d0_v); end
        checks++; if (hs_low != 96) begin errors++; $display("FAIL hsync width: got %0d pixels expected 96", hs_low); end
    endtask

    // Two full frames on the reduced raster (15x10, CLK_DIV=4)
    task automatic test_frame();
        int   h, v, cyc, ticks, t0, t1, vs_low, pe_cnt;
        logic exp_valid, exp_hs, exp_vs, exp_tick, exp_pe;
        cyc = 0; ticks = 0; t0 = -1; t1 = -1; vs_low = 0; pe_cnt = 0;
        apply_reset();
        repeat (4) @(negedge clk);
        for (int p = 0; p < 300; p++) begin
            h = p % 15;
            v = (p / 15) % 10;
            exp_valid = (h < 8) && (v < 6);
            exp_hs    = !((h >= 10) && (h < 13));
            exp_vs    = !((v >= 7) && (v < 9));
            checks++; if (d1_h !== 10'(h)) begin errors++; $display("FAIL frame h_cnt p %0d: got %0d expected %0d", p, d1_h, h); end
            checks++; if (d1_v !== 10'(v)) begin errors++; $display("FAIL frame v_cnt p %0d: got %0d expected %0d", p, d1_v, v); end
            checks++; if (d1_valid !== exp_valid) begin errors++; $display("FAIL frame valid p %0d: got %0b expected %0b", p, d1_valid, exp_valid); end
            checks++; if (d1_hsync !== exp_hs) begin errors++; $display("FAIL frame hsync p %0d: got %0b expected %0b", p, d1_hsync, exp_hs); end
            checks++; if (d1_vsync !== exp_vs) begin errors++; $display("FAIL frame vsync p %0d: got %0b expected %0b", p, d1_vsync, exp_vs); end
            if (h == 0 && d1_vsync === 1'b0) vs_low++;
            for (int k = 0; k < 4; k++) begin
                exp_tick = (k == 0) && (h == 0) && (v == 6);
                exp_pe   = (k == 3);
                checks++; if (d1_tick !== exp_tick) begin errors++; $display("FAIL frame_tick p %0d k %0d: got %0b expected %0b", p, k, d1_tick, exp_tick); end
                checks++; if (d1_pix_en !== exp_pe) begin errors++; $display("FAIL frame pix_en p %0d k %0d: got %0b expected %0b", p, k, d1_pix_en, exp_pe); end
                if (d1_tick === 1'b1) begin
                    ticks++;
                    if (t0 < 0) t0 = cyc; else t1 = cyc;
                end
                if (p < 150 && d1_pix_en === 1'b1) pe_cnt++;
                cyc++;
                @(negedge clk);
            end
        end
        checks++; if (d1_h !== 10'd0 || d1_v !== 10'd0) begin errors++; $display("FAIL frame wrap: got (%0d,%0d) expected (0,0)", d1_h, d1_v); end
        checks++; if (ticks != 2) begin errors++; $display("FAIL frame_tick count: got %0d expected 2", ticks); end
        checks++; if (t1 - t0 != 600) begin errors++; $display("FAIL frame_tick spacing: got %0d expected 600", t1 - t0); end
        checks++; if (vs_low != 4) begin errors++; $display("FAIL vsync lines: got %0d expected 4", vs_low); end
        checks++; if (pe_cnt != 150) begin errors++; $display("FAIL pix_en per frame: got %0d expected 150", pe_cnt); end
    endtask

    // Asynchronous reset mid-frame, then restart
    task automatic test_reset_mid();
        bit   found;
        logic exp_pe;
        found = 1'b0;
        apply_reset();
        for (int n = 0; n < 2000 && !found; n++) begin
            if (d1_h === 10'd5 && d1_v === 10'd3) found = 1'b1;
            else @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL mid reset: position (5,3) not reached, at (%0d,%0d)", d1_h, d1_v); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (d1_h !== 10'd14) begin errors++; $display("FAIL mid reset h_cnt: got %0d expected 14", d1_h); end
        checks++; if (d1_v !== 10'd9) begin errors++; $display("FAIL mid reset v_cnt: got %0d expected 9", d1_v); end
        checks++; if (d1_valid !== 1'b0) begin errors++; $display("FAIL mid reset valid: got %0b expected 0", d1_valid); end
        checks++; if (d1_hsync !== 1'b1 || d1_vsync !== 1'b1) begin errors++; $display("FAIL mid reset syncs: got %0b%0b expected 11", d1_hsync, d1_vsync); end
        checks++; if (d1_tick !== 1'b0 || d1_pix_en !== 1'b0) begin errors++; $display("FAIL mid reset tick/pix_en: got %0b/%0b expected 0/0", d1_tick, d1_pix_en); end
        checks++; if (d0_h !== 10'd799 || d0_v !== 10'd524) begin errors++; $display("FAIL mid reset d0: got (%0d,%0d) expected (799,524)", d0_h, d0_v); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            exp_pe = (c == 3);
            checks++; if (d1_pix_en !== exp_pe) begin errors++; $display("FAIL restart pix_en cycle %0d: got %0b expected %0b", c, d1_pix_en, exp_pe); end
            if (c == 4) begin
                checks++; if (d1_h !== 10'd0 || d1_v !== 10'd0) begin errors++; $display("FAIL restart wrap: got (%0d,%0d) expected (0,0)", d1_h, d1_v); end
                checks++; if (d1_valid !== 1'b1 || d1_tick !== 1'b0) begin errors++; $display("FAIL restart valid/tick: got %0b/%0b expected 1/0", d1_valid, d1_tick); end
            end
            @(negedge clk);
        end
    endtask

    // CLK_DIV=1 and active-high syncs: advance every clock
    task automatic test_clkdiv1();
        int   h, v;
        logic exp_hs, exp_valid;
        apply_reset();
        checks++; if (d2_pix_en !== 1'b1 || d2_h !== 10'd799) begin errors++; $display("FAIL div1 cycle 0: got pix_en %0b h %0d expected 1 799", d2_pix_en, d2_h); end
        for (int c = 1; c <= 801; c++) begin
            @(negedge clk);
            h = (c - 1) % 800;
            v = (c - 1) / 800;
            exp_hs    = (h >= 656) && (h < 752);
            exp_valid = (h < 640);
            checks++; if (d2_pix_en !== 1'b1) begin errors++; $display("FAIL div1 pix_en cycle %0d: got %0b expected 1", c, d2_pix_en); end
            checks++; if (d2_h !== 10'(h) || d2_v !== 10'(v)) begin errors++; $display("FAIL div1 counters cycle %0d: got (%0d,%0d) expected (%0d,%0d)", c, d2_h, d2_v, h, v); end
            checks++; if (d2_hsync !== exp_hs) begin errors++; $display("FAIL div1 hsync h %0d: got %0b expected %0b", h, d2_hsync, exp_hs); end
            checks++; if (d2_valid !== exp_valid) begin errors++; $display("FAIL div1 valid h %0d: got %0b expected %0b", h, d2_valid, exp_valid); end
            checks++; if (d2_vsync !== 1'b0) begin errors++; $display("FAIL div1 vsync cycle %0d: got %0b expected 0", c, d2_vsync); end
        end
    endtask

    initial begin
        test_reset();
        test_pix_en();
        test_line();
        test_frame();
        test_reset_mid();
        test_clkdiv1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
